pkt_arbiter: RTL and testbench
==============================

# pkt_arbiter

Packet-level round-robin scheduler between the router's four input queues and its four output queues. Each cycle it picks one head-of-queue packet whose destination output queue has space, pops it, holds it in a single staging register and writes it into the selected output queue. It sequences the shared routing path, sustains one packet per cycle, and never grants a packet whose output port is full, so a blocked destination does not stall other ports.

## Interface
- ROUTERID, 0, selects the destID→port map (0 or 1)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset: synchronous, active-high
- pkt_in  input  [3:0] pkt_t (32 b each)  head packet of input queue i; valid when pkt_in_avail[i]
- pkt_in_avail  input  4  input queue i non-empty
- pop  output  4  one-hot; pops input queue i at this edge
- out_free  input  4  output queue j can accept a write at this edge
- pkt_out  output  [3:0] pkt_t  write data to output queue j (0 when not written)
- pkt_out_avail  output  4  one-hot write enable to output queue j
- busy  output  1  staging register holds a packet
- stall_cnt  output  8  saturating count of cycles a held packet waited on out_free

## Operation
- Port map dport(destID):
  - ROUTERID 0: 0→0, 1→2, 2→3, else→1.
  - ROUTERID 1: 3→0, 4→1, 5→2, else→3.
- State: hold (pkt_t), hold_port (2 b), busy, rr_ptr (2 b), stall_cnt.
- Send (comb): if busy and out_free[hold_port]:
  - pkt_out_avail[hold_port]=1, pkt_out[hold_port]=hold.
  - Send completes at the edge.
- Eligibility (comb): elig[i] = pkt_in_avail[i] && out_free[dport(pkt_in[i].destID)] && !(sending && dport(pkt_in[i].destID)==hold_port).
  - The excluded port is written this cycle, so its free status is stale.
- Grant allowed when !busy, or when busy and sending this cycle.
- Grant selection: first elig[i] scanning rr_ptr, rr_ptr+1, … mod 4.
- On grant of port g:
  - pop[g]=1 (comb, same cycle).
  - At the edge: hold←pkt_in[g], hold_port←dport, busy←1, rr_ptr←(g+1) mod 4.
- Send with no grant: busy←0.
- Busy and not sending: hold is kept, pop=0, stall_cnt increments and saturates at 255.
- stall_cnt clears on each completed send.
- rr_ptr changes only on grant.
- pop has at most one bit set. pkt_out_avail has at most one bit set.

## Timing
- Reset (rst=1 at an edge): busy=0, hold=0, hold_port=0, rr_ptr=0, stall_cnt=0.
- During the reset cycle all outputs are forced low: pop=0, pkt_out_avail=0, pkt_out=0.
- Reset mid-operation discards the held packet. No pop or write occurs in any cycle rst is high.
- Latency: packet popped at edge N is written to its output queue at edge N+1 at the earliest.
- Throughput: 1 packet/cycle when destinations differ or stay free.
- Simultaneous send and grant: both happen at the same edge. The held packet is written while the new one is loaded.
- All inputs are sampled pre-edge. No combinational path from pkt_out_avail back into out_free is assumed.
- No request, or all requesters blocked: pop=0. State holds apart from the send path.

## Test plan
- Single request:
  - Stimulus: ROUTERID 0, pkt_in_avail=0001, destID=2, out_free=1111.
  - Required: pop=0001 at cycle 1; pkt_out_avail=1000 with that packet at cycle 2; busy 1 for exactly one cycle.
- Fairness:
  - Stimulus: all four queues continuously non-empty, distinct destinations, out_free=1111.
  - Required: grant order 0,1,2,3,0,1…; one pop per cycle.
- Blocked destination:
  - Stimulus: port 0 head dest→port 2, out_free[2]=0; port 1 has a packet for port 0.
  - Required: port 1 is granted and delivered; port 0 is never popped until out_free[2]=1.
- Held stall:
  - Stimulus: grant a packet, then deassert out_free[hold_port] for 300 cycles.
  - Required: stall_cnt saturates at 255; pop stays 0; on release the packet is written and stall_cnt returns to 0.
- Same-dest back-to-back:
  - Stimulus: two queues with packets for the same port.
  - Required: the second packet is not granted in the cycle the first is written; it is granted the following cycle.
- Reset while busy:
  - Stimulus: assert rst with busy=1.
  - Required: next cycle busy=0, no write of the held packet, rr_ptr=0.
- ROUTERID 1 mapping:
  - Stimulus: destIDs 3, 4, 5, 0.
  - Required: written to ports 0, 1, 2, 3 respectively.

Source files
------------

// File: rtl/pkt_arbiter_if.sv
// Queue-side bus of the packet arbiter: four input-queue heads with pop
// strobes, four output-queue write ports with their free flags.
// Each packet is 32 bits; the destination ID occupies bits [31:24].
interface pkt_arbiter_if;
    logic [3:0][31:0] pkt_in;
    logic [3:0]       pkt_in_avail;
    logic [3:0]       pop;
    logic [3:0]       out_free;
    logic [3:0][31:0] pkt_out;
    logic [3:0]       pkt_out_avail;

    // Arbiter side: consumes queue heads and drives the output writes.
    modport master (
        input  pkt_in,
        input  pkt_in_avail,
        output pop,
        input  out_free,
        output pkt_out,
        output pkt_out_avail
    );

    // Queue side: presents heads and free flags, receives pops and writes.
    modport slave (
        output pkt_in,
        output pkt_in_avail,
        input  pop,
        output out_free,
        input  pkt_out,
        input  pkt_out_avail
    );
endinterface

// File: rtl/pkt_arbiter.sv
// Round-robin packet scheduler from four input queues to four output queues
// through a single staging register. A grant is only issued when the target
// output queue has space, so one blocked destination never stalls the rest.
module pkt_arbiter #(
    parameter bit ROUTERID = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    pkt_arbiter_if.master bus,
    output logic          busy,
    output logic [7:0]    stall_cnt
);

    logic [31:0] hold;
    logic [1:0]  hold_port;
    logic [1:0]  rr_ptr;

    logic        sending;
    logic        grant_ok;
    logic        grant_vld;
    logic        found;
    logic [1:0]  grant_idx;
    logic [3:0]  elig;
    logic [1:0]  in_port [4];

    // Destination ID to output port; the map differs per router position.
    function automatic logic [1:0] dport(input logic [7:0] dest_id);
        logic [1:0] p;
        if (ROUTERID == 1'b0) begin
            case (dest_id)
                8'd0:    p = 2'd0;
                8'd1:    p = 2'd2;
                8'd2:    p = 2'd3;
                default: p = 2'd1;
            endcase
        end else begin
            case (dest_id)
                8'd3:    p = 2'd0;
                8'd4:    p = 2'd1;
                8'd5:    p = 2'd2;
                default: p = 2'd3;
            endcase
        end
        return p;
    endfunction

    // Send condition and per-queue eligibility. The port being written this
    // cycle is excluded because its free flag does not yet reflect the write.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // otherwise synthesis infers a latch to hold it.
        sending  = busy && bus.out_free[hold_port] && !rst;
        grant_ok = !rst && (!busy || sending);
        elig     = '0;
        for (int i = 0; i < 4; i++) begin
            in_port[i] = dport(bus.pkt_in[i][31:24]);
            elig[i]    = bus.pkt_in_avail[i] && bus.out_free[in_port[i]] &&
                         !(sending && (in_port[i] == hold_port));
        end
    end

    // Round-robin pick: first eligible queue starting at rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[rr_ptr + 2'(k)]) begin
                found     = 1'b1;
                grant_idx = rr_ptr + 2'(k);
            end
        end
        grant_vld = found && grant_ok;
    end

    // Queue strobes: pop of the granted queue, write of the held packet.
    always_comb begin
        bus.pop           = '0;
        bus.pkt_out_avail = '0;
        bus.pkt_out       = '0;
        if (grant_vld) begin
            bus.pop[grant_idx] = 1'b1;
        end
        if (sending) begin
            bus.pkt_out_avail[hold_port] = 1'b1;
            bus.pkt_out[hold_port]       = hold;
        end
    end

    // Staging register, round-robin pointer and stall counter.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the staging data is reset too, so a discarded packet
            // never reappears on pkt_out after reset.
            hold      <= '0;
            hold_port <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_vld) begin
                hold      <= bus.pkt_in[grant_idx];
                hold_port <= in_port[grant_idx];
                busy      <= 1'b1;
                rr_ptr    <= grant_idx + 2'd1;
            end else if (sending) begin
                busy <= 1'b0;
            end

            if (sending) begin
                stall_cnt <= '0;
            end else if (busy && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Bench for pkt_arbiter: modelled input queues feed the ROUTERID 0 instance,
// expected output writes go to a scoreboard queue as packets are queued and
// are compared as the DUT writes them. A ROUTERID 1 instance checks its map.
module tb_pkt_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_arbiter_if bus0 ();
    pkt_arbiter_if bus1 ();

    logic       busy0, busy1;
    logic [7:0] stall0, stall1;

    pkt_arbiter #(.ROUTERID(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .busy      (busy0),
        .stall_cnt (stall0)
    );

    pkt_arbiter #(.ROUTERID(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .busy      (busy1),
        .stall_cnt (stall1)
    );

    int checks = 0;
    int errors = 0;

    typedef logic [31:0] pkt_q_t [$];
    pkt_q_t      in_q [4];
    logic [33:0] exp_q [$];      // {port, packet}
    logic [3:0]  pop_s;
    int          payload_cnt = 1;

    // Present the head of each modelled input queue.
    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            bus0.pkt_in_avail[i] = (in_q[i].size() != 0);
            bus0.pkt_in[i]       = (in_q[i].size() != 0) ? in_q[i][0] : 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int q, input logic [7:0] dest, output logic [31:0] pkt);
        pkt = {dest, 24'(payload_cnt)};
        payload_cnt++;
        in_q[q].push_back(pkt);
        refresh();
    endtask

    task automatic expect_write(input logic [1:0] port, input logic [31:0] pkt);
        exp_q.push_back({port, pkt});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus0.out_free = 4'b0000;
        for (int i = 0; i < 4; i++) in_q[i].delete();
        exp_q.delete();
        refresh();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected writes never seen, required 0", name, exp_q.size());
        end
    endtask

    // Capture pops and score output writes, away from the clock edge.
    always @(negedge clk) begin
        logic [33:0] e;
        logic [3:0]  exp_avail;
        pop_s = bus0.pop;
        if (!rst && (bus0.pkt_out_avail != 4'b0000)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: pkt_out_avail=%b, required no write",
                         bus0.pkt_out_avail);
            end else begin
                e = exp_q.pop_front();
                exp_avail = 4'b0001 << e[33:32];
                if (bus0.pkt_out_avail !== exp_avail || bus0.pkt_out[e[33:32]] !== e[31:0]) begin
                    errors++;
                    $display("FAIL write: avail=%b data=%h, required avail=%b data=%h",
                             bus0.pkt_out_avail, bus0.pkt_out[e[33:32]], exp_avail, e[31:0]);
                end
            end
        end
    end

    // Input queues pop after the edge at which the DUT asserted pop.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && in_q[i].size() != 0) void'(in_q[i].pop_front());
        end
        refresh();
    end

    task automatic test_reset();
        logic [31:0] p;
        do_reset();
        rst = 1'b1;
        bus0.out_free = 4'b1111;
        push_pkt(0, 8'd0, p);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0000 || bus0.pkt_out_avail !== 4'b0000 || bus0.pkt_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pop=%b avail=%b, required all zero",
                     bus0.pop, bus0.pkt_out_avail);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || stall0 !== 8'd0 || bus0.pop !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall=%0d pop=%b, required 0 0 0000",
                     busy0, stall0, bus0.pop);
        end
        tick();
        for (int i = 0; i < 4; i++) in_q[i].delete();
        refresh();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] p;
        do_reset();
        bus0.out_free = 4'b1111;
        push_pkt(0, 8'd2, p);
        expect_write(2'd3, p);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0001 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: pop=%b busy=%b, required 0001 0", bus0.pop, busy0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus0.pkt_out_avail !== 4'b1000 || busy0 !== 1'b1 || bus0.pop !== 4'b0000) begin
            errors++;
            $display("FAIL single_write: avail=%b busy=%b pop=%b, required 1000 1 0000",
                     bus0.pkt_out_avail, busy0, bus0.pop);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b, required 0", busy0);
        end
        check_drained("single_drained");
    endtask

    task automatic test_fairness();
        logic [31:0] p;
        logic [7:0]  dest_of [4];
        logic [3:0]  exp_pop;
        int          bad = 0;
        dest_of = '{8'd0, 8'd7, 8'd1, 8'd2};   // ports 0,1,2,3
        do_reset();
        bus0.out_free = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                push_pkt(i, dest_of[i], p);
                expect_write(2'(i), p);
            end
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_pop = 4'b0001 << (k % 4);
            checks++;
            if (bus0.pop !== exp_pop) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL fair_pop[%0d]: pop=%b, required %b", k, bus0.pop, exp_pop);
            end
            tick();
        end
        tick();
        tick();
        check_drained("fair_drained");
    endtask

    task automatic test_blocked();
        logic [31:0] p0, p1;
        do_reset();
        bus0.out_free = 4'b1011;
        push_pkt(0, 8'd1, p0);     // port 2, blocked
        push_pkt(1, 8'd0, p1);     // port 0, free
        expect_write(2'd0, p1);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0010) begin
            errors++;
            $display("FAIL blocked_grant: pop=%b, required 0010", bus0.pop);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus0.pop[0] !== 1'b0) begin
                errors++;
                $display("FAIL blocked_hold[%0d]: pop=%b, required pop[0]=0", k, bus0.pop);
            end
            tick();
        end
        bus0.out_free = 4'b1111;
        expect_write(2'd2, p0);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0001) begin
            errors++;
            $display("FAIL blocked_release: pop=%b, required 0001", bus0.pop);
        end
        tick();
        tick();
        check_drained("blocked_drained");
    endtask

    task automatic test_stall();
        logic [31:0] p0, p1;
        int          bad = 0;
        do_reset();
        bus0.out_free = 4'b1111;
        push_pkt(0, 8'd0, p0);
        expect_write(2'd0, p0);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0001) begin
            errors++;
            $display("FAIL stall_grant: pop=%b, required 0001", bus0.pop);
        end
        tick();
        bus0.out_free = 4'b1110;
        push_pkt(1, 8'd7, p1);
        expect_write(2'd1, p1);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus0.pop !== 4'b0000 || bus0.pkt_out_avail !== 4'b0000) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_quiet: %0d cycles with pop or write, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (stall0 !== 8'd255 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_sat: stall_cnt=%0d busy=%b, required 255 1", stall0, busy0);
        end
        tick();
        bus0.out_free = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0010) begin
            errors++;
            $display("FAIL stall_send_grant: pop=%b, required 0010", bus0.pop);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall0 !== 8'd0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_clear: stall_cnt=%0d busy=%b, required 0 1", stall0, busy0);
        end
        tick();
        tick();
        check_drained("stall_drained");
    endtask

    task automatic test_back_to_back();
        logic [31:0] p0, p1;
        do_reset();
        bus0.out_free = 4'b1111;
        push_pkt(0, 8'd0, p0);
        push_pkt(1, 8'd0, p1);
        expect_write(2'd0, p0);
        expect_write(2'd0, p1);
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first: pop=%b, required 0001", bus0.pop);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_excluded: pop=%b, required 0000", bus0.pop);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_second: pop=%b, required 0010", bus0.pop);
        end
        tick();
        tick();
        check_drained("b2b_drained");
    endtask

    task automatic test_reset_busy();
        logic [31:0] p0, p1, p2;
        do_reset();
        bus0.out_free = 4'b1111;
        push_pkt(0, 8'd0, p0);     // discarded by reset, never written
        @(negedge clk);
        tick();
        bus0.out_free = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_held: busy=%b, required 1", busy0);
        end
        tick();
        rst = 1'b1;
        bus0.out_free = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0000 || bus0.pkt_out_avail !== 4'b0000) begin
            errors++;
            $display("FAIL rstbusy_quiet: pop=%b avail=%b, required 0000 0000",
                     bus0.pop, bus0.pkt_out_avail);
        end
        tick();
        rst = 1'b0;
        push_pkt(0, 8'd0, p1);
        push_pkt(1, 8'd7, p2);
        expect_write(2'd0, p1);
        expect_write(2'd1, p2);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || bus0.pop !== 4'b0001 || bus0.pkt_out_avail !== 4'b0000) begin
            errors++;
            $display("FAIL rstbusy_after: busy=%b pop=%b avail=%b, required 0 0001 0000",
                     busy0, bus0.pop, bus0.pkt_out_avail);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus0.pop !== 4'b0010) begin
            errors++;
            $display("FAIL rstbusy_rr: pop=%b, required 0010", bus0.pop);
        end
        tick();
        tick();
        check_drained("rstbusy_drained");
    endtask

    task automatic test_router1_map();
        logic [7:0]  dests [4];
        logic [1:0]  ports [4];
        logic [31:0] p;
        logic [3:0]  exp_avail;
        dests = '{8'd3, 8'd4, 8'd5, 8'd0};
        ports = '{2'd0, 2'd1, 2'd2, 2'd3};
        bus1.out_free = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            p = {dests[i], 24'(32'hA00 + i)};
            bus1.pkt_in[0]     = p;
            bus1.pkt_in_avail  = 4'b0001;
            @(negedge clk);
            checks++;
            if (bus1.pop !== 4'b0001) begin
                errors++;
                $display("FAIL r1_pop[%0d]: pop=%b, required 0001", i, bus1.pop);
            end
            tick();
            bus1.pkt_in_avail = 4'b0000;
            bus1.pkt_in[0]    = 32'h0;
            exp_avail = 4'b0001 << ports[i];
            @(negedge clk);
            checks++;
            if (bus1.pkt_out_avail !== exp_avail || bus1.pkt_out[ports[i]] !== p) begin
                errors++;
                $display("FAIL r1_map[dest %0d]: avail=%b data=%h, required %b %h",
                         dests[i], bus1.pkt_out_avail, bus1.pkt_out[ports[i]], exp_avail, p);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus1.pkt_in       = '0;
        bus1.pkt_in_avail = 4'b0000;
        bus1.out_free     = 4'b0000;
        bus0.out_free     = 4'b0000;
        refresh();
        test_reset();
        test_single();
        test_fairness();
        test_blocked();
        test_stall();
        test_back_to_back();
        test_reset_busy();
        test_router1_map();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
